// File: rtl/constraint_sample_gen.sv
// Random-solution sampler initiator: fills candidates from a 32-bit Galois LFSR,
// checks them against an external combinational checker and offers passing ones downstream.
module constraint_sample_gen #(
    parameter int          TOTAL_W   = 64,
    parameter int          MAX_TRIES = 16,
    parameter logic [31:0] SEED      = 32'hACE1_0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        num_req,
    input  logic               seed_load,
    input  logic [31:0]        seed,
    output logic [TOTAL_W-1:0] cand_out,
    input  logic               check_in,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [TOTAL_W-1:0] sol_data,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [15:0]        tries,
    output logic [1:0]         state_dbg
);

    localparam int          BEATS     = (TOTAL_W + 31) / 32;
    localparam int          CAND_W    = BEATS * 32;
    localparam int          BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] SEED_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0] MAX_T     = 16'(MAX_TRIES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, CHECK, HOLD} state_t;

    state_t              state_q, state_d;
    logic [31:0]         lfsr_q, lfsr_next;
    logic [CAND_W-1:0]   cand_q, cand_fill;
    logic [BEAT_W-1:0]   beat_q;
    logic [15:0]         tries_q, remaining_q;
    logic                sol_valid_q, done_q, fail_q;
    logic                last_beat, reject_final, handshake;

    // Handshake: a solution transfers on a rising edge where sol_valid && sol_ready;
    // once raised, sol_valid and sol_data hold until that edge (abort/rst excepted).
    assign lfsr_next    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    assign last_beat    = (beat_q == LAST_BEAT);
    assign reject_final = (tries_q == MAX_T - 16'd1);
    assign handshake    = (state_q == HOLD) && sol_valid_q && sol_ready;

    generate
        if (BEATS > 1) begin : g_multi
            assign cand_fill = {cand_q[CAND_W-33:0], lfsr_q};
        end else begin : g_single
            assign cand_fill = lfsr_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start && !seed_load && num_req != 16'd0) state_d = FILL;
            FILL:  if (last_beat) state_d = CHECK;
            CHECK: begin
                if (check_in)          state_d = HOLD;
                else if (reject_final) state_d = IDLE;
                else                   state_d = FILL;
            end
            HOLD:  if (handshake) state_d = (remaining_q == 16'd1) ? IDLE : FILL;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= SEED_INIT;
            cand_q      <= '0;
            beat_q      <= '0;
            tries_q     <= '0;
            remaining_q <= '0;
            sol_valid_q <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            if (abort) begin
                sol_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (seed_load) begin
                            lfsr_q <= (seed == 32'h0) ? 32'h1 : seed;
                        end else if (start) begin
                            if (num_req == 16'd0) begin
                                done_q <= 1'b1;
                            end else begin
                                remaining_q <= num_req;
                                tries_q     <= '0;
                                beat_q      <= '0;
                            end
                        end
                    end
                    FILL: begin
                        cand_q <= cand_fill;
                        lfsr_q <= lfsr_next;
                        beat_q <= last_beat ? '0 : beat_q + 1'b1;
                    end
                    CHECK: begin
                        if (!check_in) begin
                            if (reject_final) begin
                                tries_q <= MAX_T;
                                fail_q  <= 1'b1;
                            end else begin
                                tries_q <= tries_q + 16'd1;
                            end
                        end
                    end
                    HOLD: begin
                        // sol_valid rises one cycle after entering HOLD, straight from a register
                        if (!sol_valid_q) begin
                            sol_valid_q <= 1'b1;
                        end else if (sol_ready) begin
                            sol_valid_q <= 1'b0;
                            remaining_q <= remaining_q - 16'd1;
                            if (remaining_q == 16'd1) done_q  <= 1'b1;
                            else                      tries_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cand_out  = cand_q[TOTAL_W-1:0];
    assign sol_data  = cand_q[TOTAL_W-1:0];
    assign sol_valid = sol_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign fail      = fail_q;
    assign tries     = tries_q;
    assign state_dbg = state_q;

endmodule
